mux_dec_scanner: RTL

//   Registered, parametrised N-to-1 multiplexer with a companion one-hot decoder output.

---
 rtl/mux_dec_scanner.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mux_dec_scanner.sv
// Registered N-to-1 mux with one-hot decode; MANUAL select or automatic SCAN with dwell.
// Ports: clk, rst_n (sync low), en, mode, s, w, mask -> y, f, ch, valid, wrap. Option: SCAN_MASK_EN.
module mux_dec_scanner #(
    parameter int N     = 4,
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [SEL_W-1:0] s,
    input  logic [N-1:0]     w,
    input  logic [N-1:0]     mask,
    output logic [N-1:0]     y,
    output logic             f,
    output logic [SEL_W-1:0] ch,
    output logic             valid,
    output logic             wrap
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic [SEL_W-1:0] first_set;
    logic [SEL_W-1:0] next_set;
    logic             scan_live;

`ifdef SCAN_MASK_EN
    // Lowest enabled channel, used on scan entry.
    always_comb begin
        logic found;
        found     = 1'b0;
        first_set = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && mask[i]) begin
                first_set = SEL_W'(i);
                found     = 1'b1;
            end
        end
    end

    // First enabled channel circularly after ch; k = N lands back on ch.
    always_comb begin
        logic             found;
        logic [SEL_W-1:0] idx;
        found    = 1'b0;
        idx      = '0;
        next_set = ch;
        for (int k = 1; k <= N; k++) begin
            idx = ch + SEL_W'(k);
            if (!found && mask[idx]) begin
                next_set = idx;
                found    = 1'b1;
            end
        end
    end

    assign scan_live = |mask;
`else
    logic unused_mask;
    assign unused_mask = ^mask;
    assign first_set   = '0;
    assign next_set    = ch + SEL_W'(1);
    assign scan_live   = 1'b1;
`endif

    logic [SEL_W-1:0] scan_nxt;
    logic [CNT_W-1:0] scan_cnt;
    logic             scan_wrap;

    always_comb begin
        scan_nxt  = ch;
        scan_cnt  = cnt + CNT_W'(1);
        scan_wrap = 1'b0;
        if (state != SCAN) begin
            scan_nxt = first_set;
            scan_cnt = '0;
        end else if (cnt == CNT_LAST) begin
            scan_nxt  = next_set;
            scan_cnt  = '0;
            // Stepping to a channel not above the current one closes a pass.
            scan_wrap = (next_set <= ch);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            ch    <= '0;
            y     <= '0;
            f     <= 1'b0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else if (!en || (mode && !scan_live)) begin
            // Empty mask parks in IDLE so the next live edge re-enters the scan.
            state <= IDLE;
            cnt   <= '0;
            y     <= '0;
            f     <= 1'b0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else if (!mode) begin
            state <= MANUAL;
            cnt   <= '0;
            ch    <= s;
            y     <= ONE << s;
            f     <= w[s];
            valid <= 1'b1;
            wrap  <= 1'b0;
        end else begin
            state <= SCAN;
            cnt   <= scan_cnt;
            ch    <= scan_nxt;
            y     <= ONE << scan_nxt;
            f     <= w[scan_nxt];
            valid <= 1'b1;
            wrap  <= scan_wrap;
        end
    end

endmodule
